// File: rtl/index_buf_pkg.sv
// Shared types and helpers for the ping-pong width-converting index buffer.
package index_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // Bit offset of sub-word 'sel' inside a write word.
  function automatic int unsigned slice_offset(
    input int unsigned sel,
    input int unsigned wr_w,
    input int unsigned rd_w,
    input bit          msb_first
  );
    int unsigned off;
    if (msb_first) begin
      off = wr_w - rd_w - (sel * rd_w);
    end else begin
      off = sel * rd_w;
    end
    return off;
  endfunction

  function automatic logic holds_data(input bank_state_t s);
    logic res;
    case (s)
      FULL, DRAINING: res = 1'b1;
      EMPTY, FILLING: res = 1'b0;
      default:        res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/index_subword_sel.sv
// Read-side pipeline: registers bank id and slice select alongside the SRAM
// read, then picks the sub-word from the returned word into data_o.
module index_subword_sel
  import index_buf_pkg::*;
#(
  parameter  int WR_DATA_WIDTH = 8,
  parameter  int RD_DATA_WIDTH = 2,
  parameter  bit MSB_FIRST     = 1'b1,
  localparam int R             = WR_DATA_WIDTH / RD_DATA_WIDTH,
  localparam int SEL_W         = $clog2(R),
  localparam int SEL_WS        = (SEL_W > 0) ? SEL_W : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rd_acc_i,
  input  logic                     bank_i,
  input  logic [SEL_WS-1:0]        sel_i,
  input  logic [WR_DATA_WIDTH-1:0] word0_i,
  input  logic [WR_DATA_WIDTH-1:0] word1_i,
  output logic [RD_DATA_WIDTH-1:0] data_o,
  output logic                     valid_o
);

  logic                     v1_q;
  logic                     bank1_q;
  logic [SEL_WS-1:0]        sel1_q;
  logic [RD_DATA_WIDTH-1:0] data_q;
  logic [RD_DATA_WIDTH-1:0] data_d;
  logic                     valid_q;
  logic [WR_DATA_WIDTH-1:0] word_s;
  logic [RD_DATA_WIDTH-1:0] slice_s;

  always_comb begin
    word_s  = bank1_q ? word1_i : word0_i;
    slice_s = RD_DATA_WIDTH'(word_s >> slice_offset(32'(sel1_q), WR_DATA_WIDTH,
                                                     RD_DATA_WIDTH, MSB_FIRST));
    if (v1_q) begin
      data_d = slice_s;
    end else begin
      data_d = data_q;
    end
  end

  // Stage 1 tracks the SRAM access, stage 2 holds the delivered sub-word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      bank1_q <= 1'b0;
      sel1_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      v1_q <= rd_acc_i;
      if (rd_acc_i) begin
        bank1_q <= bank_i;
        sel1_q  <= sel_i;
      end
      data_q  <= data_d;
      valid_q <= v1_q;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/mem2p11_dxw_p.sv
// Behavioural model of the two-port SRAM macro: synchronous write port,
// synchronous read port whose output holds between reads.
module mem2p11_dxw_p #(
  parameter  int DEPTH = 1024,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             mew,
  input  logic [AW-1:0]    addrw,
  input  logic [WIDTH-1:0] din,
  input  logic             mer,
  input  logic [AW-1:0]    addrr,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (mew) begin
      mem_q[addrw] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (mer) begin
      dout_q <= mem_q[addrr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/index_sram_pp.sv
// Ping-pong index buffer: the writer fills one bank with wide words while the
// reader drains the other bank as narrow sub-words with a two-cycle latency.
module index_sram_pp
  import index_buf_pkg::*;
#(
  parameter  int WR_DATA_WIDTH = 8,
  parameter  int RD_DATA_WIDTH = 2,
  parameter  int WR_DATA_DEPTH = 1024,
  parameter  bit MSB_FIRST     = 1'b1,
  localparam int R             = WR_DATA_WIDTH / RD_DATA_WIDTH,
  localparam int SEL_W         = $clog2(R),
  localparam int SEL_WS        = (SEL_W > 0) ? SEL_W : 1,
  localparam int WR_ADDR_WIDTH = $clog2(WR_DATA_DEPTH),
  localparam int RD_ADDR_WIDTH = WR_ADDR_WIDTH + SEL_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic                     wr_last,
  input  logic [WR_ADDR_WIDTH-1:0] wr_addr,
  input  logic [WR_DATA_WIDTH-1:0] data_in,
  output logic                     wr_ready,
  input  logic                     rd,
  input  logic                     rd_last,
  input  logic [RD_ADDR_WIDTH-1:0] rd_addr,
  output logic                     rd_ready,
  output logic [RD_DATA_WIDTH-1:0] data_out,
  output logic                     rd_valid,
  output logic [1:0]               bank_full,
  output logic                     err_wr_overrun,
  output logic                     err_rd_underrun
);

  bank_state_t              state_q [2];
  bank_state_t              state_d [2];
  logic                     wr_bank_q;
  logic                     wr_bank_d;
  logic                     rd_bank_q;
  logic                     rd_bank_d;
  logic [1:0]               bank_full_q;
  logic [1:0]               bank_full_d;
  logic                     err_wr_q;
  logic                     err_wr_d;
  logic                     err_rd_q;
  logic                     err_rd_d;
  logic                     wr_ready_s;
  logic                     rd_ready_s;
  logic                     wr_acc_s;
  logic                     rd_acc_s;
  logic [WR_ADDR_WIDTH-1:0] rd_word_s;
  logic [SEL_WS-1:0]        rd_sel_s;
  logic [1:0]               mew_s;
  logic [1:0]               mer_s;
  logic [WR_DATA_WIDTH-1:0] dout_s [2];

  assign wr_ready_s = ~holds_data(state_q[wr_bank_q]);
  assign rd_ready_s = holds_data(state_q[rd_bank_q]);
  assign wr_acc_s   = wr & wr_ready_s;
  assign rd_acc_s   = rd & rd_ready_s;

  assign rd_word_s = rd_addr[RD_ADDR_WIDTH-1 -: WR_ADDR_WIDTH];

  if (SEL_W > 0) begin : g_sel
    assign rd_sel_s = rd_addr[SEL_W-1:0];
  end else begin : g_nosel
    assign rd_sel_s = 1'b0;
  end

  // An accepted write and an accepted read always target different banks,
  // so both updates can be applied in the same cycle.
  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (wr_acc_s) begin
      if (wr_last) begin
        state_d[wr_bank_q] = FULL;
        wr_bank_d          = ~wr_bank_q;
      end else begin
        state_d[wr_bank_q] = FILLING;
      end
    end else begin
      wr_bank_d = wr_bank_q;
    end
    if (rd_acc_s) begin
      if (rd_last) begin
        state_d[rd_bank_q] = EMPTY;
        rd_bank_d          = ~rd_bank_q;
      end else begin
        state_d[rd_bank_q] = DRAINING;
      end
    end else begin
      rd_bank_d = rd_bank_q;
    end
    err_wr_d    = err_wr_q | (wr & ~wr_ready_s);
    err_rd_d    = err_rd_q | (rd & ~rd_ready_s);
    bank_full_d = {holds_data(state_d[1]), holds_data(state_d[0])};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q[0]  <= EMPTY;
      state_q[1]  <= EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      err_wr_q    <= 1'b0;
      err_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      bank_full_q <= bank_full_d;
      err_wr_q    <= err_wr_d;
      err_rd_q    <= err_rd_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign mew_s[b] = wr_acc_s & (wr_bank_q == 1'(b));
    assign mer_s[b] = rd_acc_s & (rd_bank_q == 1'(b));

    mem2p11_dxw_p #(
      .DEPTH (WR_DATA_DEPTH),
      .WIDTH (WR_DATA_WIDTH)
    ) u_mem (
      .clk   (clk),
      .mew   (mew_s[b]),
      .addrw (wr_addr),
      .din   (data_in),
      .mer   (mer_s[b]),
      .addrr (rd_word_s),
      .dout  (dout_s[b])
    );
  end

  index_subword_sel #(
    .WR_DATA_WIDTH (WR_DATA_WIDTH),
    .RD_DATA_WIDTH (RD_DATA_WIDTH),
    .MSB_FIRST     (MSB_FIRST)
  ) u_sel (
    .clk_i    (clk),
    .rst_i    (rst),
    .rd_acc_i (rd_acc_s),
    .bank_i   (rd_bank_q),
    .sel_i    (rd_sel_s),
    .word0_i  (dout_s[0]),
    .word1_i  (dout_s[1]),
    .data_o   (data_out),
    .valid_o  (rd_valid)
  );

  assign wr_ready        = wr_ready_s;
  assign rd_ready        = rd_ready_s;
  assign bank_full       = bank_full_q;
  assign err_wr_overrun  = err_wr_q;
  assign err_rd_underrun = err_rd_q;

endmodule
